// File: rtl/byte_2_word_pkg.sv
// Shared types and constants for the byte-to-word assembler.
// Holds the FSM state enum, bus widths and the byte-ordering helper.
package byte_2_word_pkg;

    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned WORD_W             = 16;
    localparam int unsigned CNT_W              = 16;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 1024;

    typedef enum logic {
        IDLE       = 1'b0,
        HAVE_FIRST = 1'b1
    } state_e;

    function automatic logic [WORD_W-1:0] assemble_word(
        input logic [BYTE_W-1:0] first_byte,
        input logic [BYTE_W-1:0] second_byte,
        input logic              lsb_first
    );
        return lsb_first ? {second_byte, first_byte} : {first_byte, second_byte};
    endfunction

endpackage

// File: rtl/b2w_timeout_cnt.sv
// Idle-cycle counter that flags expiry of a half-received word.
// Only built when BYTE_2_WORD_TIMEOUT_EN is defined.
`ifdef BYTE_2_WORD_TIMEOUT_EN
module b2w_timeout_cnt
    import byte_2_word_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expire_o = en_i & (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || expire_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/byte_2_word.sv
// Reassembles byte pairs into 16-bit words; receive side of the word splitter.
// Define BYTE_2_WORD_TIMEOUT_EN to drop a half word after TIMEOUT_CYCLES idle ce cycles.
module byte_2_word
    import byte_2_word_pkg::*;
#(
    parameter bit          LSB_FIRST      = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic              byte_dv,
    input  logic [BYTE_W-1:0] byteee,
    input  logic              flush,
    output logic              word_dv,
    output logic [WORD_W-1:0] word,
    output logic              pending,
    output logic              timeout_err
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("byte_2_word: TIMEOUT_CYCLES must be in 2..65535");
    end

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] first_q, first_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              word_dv_q, word_dv_d;
    logic              terr_q, terr_d;
    logic              pending_q;
    logic              expire;

`ifdef BYTE_2_WORD_TIMEOUT_EN
    logic cnt_en, cnt_clr;

    // Only idle ce cycles age the held byte; any byte or flush restarts the count.
    assign cnt_en  = ce & ~byte_dv & ~flush & (state_q == HAVE_FIRST);
    assign cnt_clr = ce & (byte_dv | flush);

    b2w_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk_i    (clk),
        .rst_ni   (rst),
        .en_i     (cnt_en),
        .clr_i    (cnt_clr),
        .expire_o (expire)
    );
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        first_d   = first_q;
        word_d    = word_q;
        word_dv_d = 1'b0;
        terr_d    = 1'b0;
        if (ce) begin
            if (flush) begin
                state_d = IDLE;
                first_d = '0;
            end else if (byte_dv) begin
                if (state_q == IDLE) begin
                    first_d = byteee;
                    state_d = HAVE_FIRST;
                end else begin
                    word_d    = assemble_word(first_q, byteee, LSB_FIRST);
                    word_dv_d = 1'b1;
                    state_d   = IDLE;
                end
            end else if (expire) begin
                state_d = IDLE;
                first_d = '0;
                terr_d  = 1'b1;
            end
        end
    end

    // Pulses are recomputed every clk so they last one cycle even when ce drops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            first_q   <= '0;
            word_q    <= '0;
            word_dv_q <= 1'b0;
            terr_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            first_q   <= first_d;
            word_q    <= word_d;
            word_dv_q <= word_dv_d;
            terr_q    <= terr_d;
            pending_q <= (state_d == HAVE_FIRST);
        end
    end

    assign word_dv     = word_dv_q;
    assign word        = word_q;
    assign pending     = pending_q;
    assign timeout_err = terr_q;

endmodule

// File: doc/byte_2_word.md
BYTE_2_WORD -- requirements
Module: byte_2_word

Interface
REQ-001 Parameter: LSB_FIRST, default 1, first received byte is word[7:0] (1) or word[15:8] (0).
REQ-002 Parameter: TIMEOUT_CYCLES, default 1024, number of ce-qualified idle cycles allowed between the two bytes of a word (range 2..65535).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 ce  input  1  clock enable; byte_dv, flush and timeout counting qualified by ce=1.
REQ-006 byte_dv  input  1  byteee valid, one byte per asserted ce cycle.
REQ-007 byteee  input  8  incoming byte.
REQ-008 flush  input  1  synchronous discard of any partial word.
REQ-009 word_dv  output  1  one-cycle pulse, word valid.
REQ-010 word  output  16  assembled word, held until next word_dv.
REQ-011 pending  output  1  high while first byte is held (state HAVE_FIRST).
REQ-012 timeout_err  output  1  one-cycle pulse when a partial word is dropped by timeout.

Function
REQ-013 FSM states SHALL be IDLE and HAVE_FIRST only.
REQ-014 IDLE, ce&byte_dv&!flush: store byteee as first byte, go HAVE_FIRST, clear timeout counter.
REQ-015 HAVE_FIRST, ce&byte_dv&!flush: register word = {byteee, first} if LSB_FIRST=1 else {first, byteee}, go IDLE.
REQ-016 word and word_dv SHALL both be registered, with word_dv high on the clock cycle after the second byte is sampled (latency 1).
REQ-017 word_dv SHALL be exactly one clk cycle wide regardless of ce.
REQ-018 word SHALL change only on the edge that raises word_dv.
REQ-019 Back-to-back bytes on consecutive ce cycles SHALL be accepted with no gaps; throughput is one word per two accepted bytes.
REQ-020 ce=0: FSM, counter and stored byte frozen; byte_dv ignored.
REQ-021 flush with ce=1 SHALL force IDLE and discard the stored byte; a simultaneous byte_dv is dropped; no word_dv and no timeout_err are produced.
REQ-022 pending SHALL be a registered decode of state == HAVE_FIRST.

Reset
REQ-023 rst=0 SHALL immediately force state IDLE, word=16'h0000, word_dv=0, timeout_err=0, pending=0, counter=0, stored byte=0.
REQ-024 Reset mid-word SHALL discard the partial byte, and the first byte_dv after release is treated as a first byte.

Configuration
REQ-025 Macro BYTE_2_WORD_TIMEOUT_EN defined: in HAVE_FIRST the counter increments each ce cycle without byte_dv; on reaching TIMEOUT_CYCLES-1 the block returns to IDLE and pulses timeout_err once.
REQ-026 Timeout expiry coinciding with ce&byte_dv: the byte completes the word, and no timeout_err is raised.
REQ-027 Timeout expiry coinciding with flush: flush wins, and no timeout_err is raised.
REQ-028 Macro undefined: no counter logic, timeout_err tied 0, and HAVE_FIRST waits indefinitely.

Structure
REQ-029 Package byte_2_word_pkg SHALL hold the state enum (IDLE, HAVE_FIRST), BYTE_W=8, WORD_W=16 and the default TIMEOUT_CYCLES.
REQ-030 Sub-module b2w_timeout_cnt (enable, clear, expire output) SHALL be instantiated only under BYTE_2_WORD_TIMEOUT_EN.
REQ-031 Block SHALL be the receive-side counterpart of the existing word splitter, so that splitter output bytes in order rebuild the original word with LSB_FIRST=1.

Verification
REQ-032 ce=1, LSB_FIRST=1, bytes 8'h34 then 8'h12 on consecutive cycles -> word_dv one cycle later, word=16'h1234.
REQ-033 LSB_FIRST=0, bytes 8'hAB, 8'hCD with ce toggling 1,0,1 -> word=16'hABCD, and the byte during ce=0 is ignored.
REQ-034 Timeout enabled, TIMEOUT_CYCLES=4, byte 8'h55 then idle -> timeout_err pulse after 4 ce cycles; next bytes 8'h01, 8'h02 -> word=16'h0201.
REQ-035 Byte 8'h77, then flush together with byte 8'h88, then 8'h11, 8'h22 -> no word_dv for 8'h77/8'h88, then word=16'h2211.
REQ-036 rst low while pending=1 -> all outputs zero at once; after release bytes 8'hEF, 8'hBE -> word=16'hBEEF.
REQ-037 Loopback: word splitter driven with 16'hA5C3 -> byte_2_word emits word=16'hA5C3, single word_dv.
